// File: rtl/rv32i_inst_encoder.sv
// ---------------------------------------------------------------------------
// rv32i_inst_encoder
// Field-level RV32I instruction encoder and program loader. It accepts one
// instruction request at a time, packs it into a 32-bit word, and writes the
// word into instruction memory at a self-incrementing byte address. Once a
// HALT word has been written it stops until START restarts the program.
//
// Ports
//   i_clk, i_rst_n        clock (rising edge), asynchronous active-low reset
//   i_req_valid/o_req_ready  request handshake (ready only in IDLE)
//   i_req_fmt             0=R 1=I 2=S 3=B 4=U 5=J 6=HALT 7=reserved
//   i_req_opcode/funct3/funct7/rd/rs1/rs2/imm  instruction fields
//   i_start               restart program at BASE_ADDR (IDLE/DONE only)
//   i_mem_ready           I-mem accepted the current write
//   o_i_mem_csn/o_i_mem_wen  I-mem chip select / write enable, active low
//   o_i_mem_addr          byte address of the write (wraps mod 2^ADDR_W)
//   o_i_mem_dout          encoded instruction
//   o_count               words written since reset/START, saturating
//   o_err                 sticky: request rejected or address wrapped
//   o_done                HALT word written
// ---------------------------------------------------------------------------
module rv32i_inst_encoder #(
    parameter int unsigned ADDR_W    = 12,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic [2:0]        i_req_fmt,
    input  logic [6:0]        i_req_opcode,
    input  logic [2:0]        i_req_funct3,
    input  logic [6:0]        i_req_funct7,
    input  logic [4:0]        i_req_rd,
    input  logic [4:0]        i_req_rs1,
    input  logic [4:0]        i_req_rs2,
    input  logic [31:0]       i_req_imm,
    input  logic              i_start,
    input  logic              i_mem_ready,
    output logic              o_i_mem_csn,
    output logic              o_i_mem_wen,
    output logic [ADDR_W-1:0] o_i_mem_addr,
    output logic [31:0]       o_i_mem_dout,
    output logic [15:0]       o_count,
    output logic              o_err,
    output logic              o_done
);

    localparam logic [2:0] FMT_R    = 3'd0;
    localparam logic [2:0] FMT_I    = 3'd1;
    localparam logic [2:0] FMT_S    = 3'd2;
    localparam logic [2:0] FMT_B    = 3'd3;
    localparam logic [2:0] FMT_U    = 3'd4;
    localparam logic [2:0] FMT_J    = 3'd5;
    localparam logic [2:0] FMT_HALT = 3'd6;

    localparam logic [31:0]       HALT_WORD = 32'h0000_8067;
    localparam logic [ADDR_W-1:0] L_BASE    = ADDR_W'(BASE_ADDR);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    // Packs one request; bit 32 is the accept flag (range/alignment/format ok).
    function automatic logic [32:0] f_encode(
        input logic [2:0]  fmt,
        input logic [6:0]  op,
        input logic [2:0]  f3,
        input logic [6:0]  f7,
        input logic [4:0]  rd,
        input logic [4:0]  rs1,
        input logic [4:0]  rs2,
        input logic [31:0] imm
    );
        logic        ok;
        logic [31:0] w;
        logic        is_shift;
        logic        imm12_ok;
        ok       = 1'b0;
        w        = 32'h0000_0000;
        // OP-IMM shifts carry funct7 in the upper immediate bits
        is_shift = (op == 7'b0010011) && ((f3 == 3'b001) || (f3 == 3'b101));
        imm12_ok = (imm[31:11] == 21'h00_0000) || (imm[31:11] == 21'h1F_FFFF);
        case (fmt)
            FMT_R: begin
                ok = 1'b1;
                w  = {f7, rs2, rs1, f3, rd, op};
            end
            FMT_I: begin
                if (is_shift) begin
                    ok = (imm[31:5] == 27'h000_0000);
                    w  = {f7, imm[4:0], rs1, f3, rd, op};
                end else begin
                    ok = imm12_ok;
                    w  = {imm[11:0], rs1, f3, rd, op};
                end
            end
            FMT_S: begin
                ok = imm12_ok;
                w  = {imm[11:5], rs2, rs1, f3, imm[4:0], op};
            end
            FMT_B: begin
                ok = ((imm[31:12] == 20'h0_0000) || (imm[31:12] == 20'hF_FFFF)) && (imm[0] == 1'b0);
                w  = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
            end
            FMT_U: begin
                ok = 1'b1;
                w  = {imm[31:12], rd, op};
            end
            FMT_J: begin
                ok = ((imm[31:20] == 12'h000) || (imm[31:20] == 12'hFFF)) && (imm[0] == 1'b0);
                w  = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
            end
            FMT_HALT: begin
                ok = 1'b1;
                w  = HALT_WORD;
            end
            default: begin
                ok = 1'b0;
                w  = 32'h0000_0000;
            end
        endcase
        return {ok, w};
    endfunction

    state_t            r_state;
    logic              r_is_halt;
    logic              r_req_ready;
    logic              r_mem_csn;
    logic              r_mem_wen;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [31:0]       r_mem_dout;
    logic [15:0]       r_count;
    logic              r_err;
    logic              r_done;

    logic [32:0]       w_enc;
    logic              w_wrap;

    // Combinational encode of the presented request and wrap detection.
    always_comb begin
        w_enc  = f_encode(i_req_fmt, i_req_opcode, i_req_funct3, i_req_funct7,
                          i_req_rd, i_req_rs1, i_req_rs2, i_req_imm);
        // Last word-aligned address: the next increment wraps to zero
        w_wrap = &r_mem_addr[ADDR_W-1:2];
    end

    // Loader FSM with all outputs registered.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= S_IDLE;
            r_is_halt   <= 1'b0;
            r_req_ready <= 1'b1;
            r_mem_csn   <= 1'b1;
            r_mem_wen   <= 1'b1;
            r_mem_addr  <= L_BASE;
            r_mem_dout  <= 32'h0000_0000;
            r_count     <= 16'h0000;
            r_err       <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (i_start) begin
                        // Restart wins over a simultaneous request
                        r_state     <= S_IDLE;
                        r_req_ready <= 1'b1;
                        r_mem_addr  <= L_BASE;
                        r_count     <= 16'h0000;
                        r_err       <= 1'b0;
                        r_done      <= 1'b0;
                    end else if ((r_state == S_IDLE) && i_req_valid) begin
                        if (w_enc[32]) begin
                            r_state     <= S_WRITE;
                            r_is_halt   <= (i_req_fmt == FMT_HALT);
                            r_mem_dout  <= w_enc[31:0];
                            r_req_ready <= 1'b0;
                            r_mem_csn   <= 1'b0;
                            r_mem_wen   <= 1'b0;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end else begin
                        r_state <= r_state;
                    end
                end
                S_WRITE: begin
                    if (i_mem_ready) begin
                        r_mem_csn  <= 1'b1;
                        r_mem_wen  <= 1'b1;
                        r_mem_addr <= r_mem_addr + ADDR_W'(4);
                        if (w_wrap) begin
                            r_err <= 1'b1;
                        end else begin
                            r_err <= r_err;
                        end
                        if (r_count != 16'hFFFF) begin
                            r_count <= r_count + 16'd1;
                        end else begin
                            r_count <= r_count;
                        end
                        if (r_is_halt) begin
                            r_state     <= S_DONE;
                            r_done      <= 1'b1;
                            r_req_ready <= 1'b0;
                        end else begin
                            r_state     <= S_IDLE;
                            r_req_ready <= 1'b1;
                        end
                    end else begin
                        r_state <= S_WRITE;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_req_ready <= 1'b1;
                    r_mem_csn   <= 1'b1;
                    r_mem_wen   <= 1'b1;
                end
            endcase
        end
    end

    assign o_req_ready  = r_req_ready;
    assign o_i_mem_csn  = r_mem_csn;
    assign o_i_mem_wen  = r_mem_wen;
    assign o_i_mem_addr = r_mem_addr;
    assign o_i_mem_dout = r_mem_dout;
    assign o_count      = r_count;
    assign o_err        = r_err;
    assign o_done       = r_done;

endmodule

// File: tb/tb_rv32i_inst_encoder.sv
// ---------------------------------------------------------------------------
// tb_rv32i_inst_encoder
// Directed-vector bench for rv32i_inst_encoder with hand-computed instruction
// words. A 4-bit address space makes the wrap reachable in four writes.
// ---------------------------------------------------------------------------
module tb_rv32i_inst_encoder;

    localparam int unsigned AW = 4;

    logic          clk;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic [2:0]    req_fmt;
    logic [6:0]    req_opcode;
    logic [2:0]    req_funct3;
    logic [6:0]    req_funct7;
    logic [4:0]    req_rd;
    logic [4:0]    req_rs1;
    logic [4:0]    req_rs2;
    logic [31:0]   req_imm;
    logic          start;
    logic          mem_ready;
    logic          mem_csn;
    logic          mem_wen;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_dout;
    logic [15:0]   count;
    logic          err;
    logic          done;

    int n_checks;
    int n_fails;

    rv32i_inst_encoder #(.ADDR_W(AW), .BASE_ADDR(0)) u_dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_req_valid  (req_valid),
        .o_req_ready  (req_ready),
        .i_req_fmt    (req_fmt),
        .i_req_opcode (req_opcode),
        .i_req_funct3 (req_funct3),
        .i_req_funct7 (req_funct7),
        .i_req_rd     (req_rd),
        .i_req_rs1    (req_rs1),
        .i_req_rs2    (req_rs2),
        .i_req_imm    (req_imm),
        .i_start      (start),
        .i_mem_ready  (mem_ready),
        .o_i_mem_csn  (mem_csn),
        .o_i_mem_wen  (mem_wen),
        .o_i_mem_addr (mem_addr),
        .o_i_mem_dout (mem_dout),
        .o_count      (count),
        .o_err        (err),
        .o_done       (done)
    );

    // Free-running clock, 10 time units per period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (act !== exp) begin
            n_fails = n_fails + 1;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // Present one request for one clock edge, then drop valid.
    task automatic send(input logic [2:0] fmt, input logic [6:0] op, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [31:0] imm);
        @(negedge clk);
        req_fmt    = fmt;
        req_opcode = op;
        req_funct3 = f3;
        req_funct7 = f7;
        req_rd     = rd;
        req_rs1    = rs1;
        req_rs2    = rs2;
        req_imm    = imm;
        req_valid  = 1'b1;
        @(posedge clk);
        #1;
        req_valid  = 1'b0;
    endtask

    // Full write with mem_ready held high: check the word, address and strobes.
    task automatic wr(input string tag, input logic [2:0] fmt, input logic [6:0] op,
                      input logic [2:0] f3, input logic [6:0] f7, input logic [4:0] rd,
                      input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm,
                      input logic [31:0] exp_word, input logic [AW-1:0] exp_addr);
        logic [AW-1:0] nxt;
        send(fmt, op, f3, f7, rd, rs1, rs2, imm);
        chk({tag, "_dout"}, mem_dout, exp_word);
        chk({tag, "_addr"}, 32'(mem_addr), 32'(exp_addr));
        chk({tag, "_csn_wen"}, {30'd0, mem_csn, mem_wen}, 32'd0);
        @(posedge clk);
        #1;
        nxt = exp_addr + 4'd4;
        chk({tag, "_csn_after"}, 32'(mem_csn), 32'd1);
        chk({tag, "_addr_after"}, 32'(mem_addr), 32'(nxt));
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    initial begin
        n_checks   = 0;
        n_fails    = 0;
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_fmt    = 3'd0;
        req_opcode = 7'd0;
        req_funct3 = 3'd0;
        req_funct7 = 7'd0;
        req_rd     = 5'd0;
        req_rs1    = 5'd0;
        req_rs2    = 5'd0;
        req_imm    = 32'd0;
        start      = 1'b0;
        mem_ready  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_csn_wen", {30'd0, mem_csn, mem_wen}, 32'd3);
        chk("rst_addr", 32'(mem_addr), 32'd0);
        chk("rst_dout", mem_dout, 32'd0);
        chk("rst_cnt_err_done", {count, 14'd0, err, done}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // addi x1,x0,5 with memory stalling three cycles
        send(3'd1, 7'b0010011, 3'b000, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5);
        chk("addi_dout", mem_dout, 32'h0050_0093);
        chk("addi_addr", 32'(mem_addr), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("stall_strobes", {29'd0, mem_csn, mem_wen, req_ready}, 32'd0);
            chk("stall_hold", {mem_dout[27:0], mem_addr}, {28'h050_0093, 4'd0});
        end
        mem_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("addi_done", {count, 12'd0, mem_addr}, {16'd1, 12'd0, 4'd4});
        chk("addi_ready", {30'd0, req_ready, mem_csn}, 32'd3);

        // beq x1,x2,-8
        wr("beq", 3'd3, 7'b1100011, 3'b000, 7'd0, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFF8,
           32'hFE20_8CE3, 4'd0 + 4'd4);

        // addi with imm 0x800 is out of range
        send(3'd1, 7'b0010011, 3'b000, 7'd0, 5'd1, 5'd0, 5'd0, 32'h0000_0800);
        chk("rej_i_err", 32'(err), 32'd1);
        chk("rej_i_nowrite", {count, 12'd0, mem_addr}, {16'd2, 12'd0, 4'd8});
        chk("rej_i_csn_ready", {30'd0, mem_csn, req_ready}, 32'd3);

        // HALT after two words
        wr("halt", 3'd6, 7'h55, 3'd7, 7'h7F, 5'd9, 5'd9, 5'd9, 32'h1234_5678,
           32'h0000_8067, 4'd8);
        chk("halt_done", {count, 14'd0, done, req_ready}, {16'd3, 14'd0, 1'b1, 1'b0});

        // Requests in DONE are ignored
        send(3'd0, 7'b0110011, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'd0);
        @(posedge clk);
        #1;
        chk("done_ignore", {count, 14'd0, mem_csn, done}, {16'd3, 14'd0, 1'b1, 1'b1});

        pulse_start();
        chk("start_clear", {count, 12'd0, mem_addr}, 32'd0);
        chk("start_flags", {29'd0, err, done, req_ready}, 32'd1);

        // Misaligned branch offset
        send(3'd3, 7'b1100011, 3'b000, 7'd0, 5'd0, 5'd1, 5'd2, 32'd3);
        chk("rej_b_err", 32'(err), 32'd1);
        chk("rej_b_nowrite", {count, 13'd0, mem_csn, req_ready, 1'b0}, {16'd0, 13'd0, 3'b110});
        pulse_start();

        // Four writes fill the 16-byte space; the last increment wraps
        wr("jal", 3'd5, 7'b1101111, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'h0000_0800,
           32'h0010_00EF, 4'd0);
        wr("srai", 3'd1, 7'b0010011, 3'b101, 7'b0100000, 5'd5, 5'd6, 5'd0, 32'd3,
           32'h4033_5293, 4'd4);
        chk("no_wrap_err", 32'(err), 32'd0);
        wr("sw", 3'd2, 7'b0100011, 3'b010, 7'd0, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFFC,
           32'hFE20_AE23, 4'd8);
        wr("lui", 3'd4, 7'b0110111, 3'd0, 7'd0, 5'd3, 5'd0, 5'd0, 32'h1234_5ABC,
           32'h1234_51B7, 4'd12);
        chk("wrap_err", {count, 15'd0, err}, {16'd4, 15'd0, 1'b1});

        // START and a request in the same cycle: START wins
        @(negedge clk);
        start      = 1'b1;
        req_valid  = 1'b1;
        req_fmt    = 3'd0;
        @(posedge clk);
        #1;
        start      = 1'b0;
        req_valid  = 1'b0;
        chk("start_vs_req", {count, 12'd0, mem_addr}, 32'd0);
        chk("start_vs_req_flags", {29'd0, err, mem_csn, req_ready}, 32'd3);

        // Reserved format is rejected
        send(3'd7, 7'b0110011, 3'd0, 7'd0, 5'd1, 5'd1, 5'd1, 32'd0);
        chk("rej_fmt7", {count, 14'd0, err, mem_csn}, {16'd0, 14'd0, 2'b11});
        pulse_start();

        // add x3,x1,x2, then a second write interrupted by reset
        wr("add", 3'd0, 7'b0110011, 3'b000, 7'b0000000, 5'd3, 5'd1, 5'd2, 32'd0,
           32'h0020_81B3, 4'd0);
        mem_ready = 1'b0;
        send(3'd0, 7'b0110011, 3'b000, 7'b0100000, 5'd4, 5'd3, 5'd1, 32'd0);
        chk("sub_dout", mem_dout, 32'h4011_8233);
        @(negedge clk);
        chk("pre_rst_csn", {count, 14'd0, mem_csn, mem_wen}, {16'd1, 16'd0});
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_abort_csn", {30'd0, mem_csn, mem_wen}, 32'd3);
        chk("rst_abort_state", {count, 12'd0, mem_addr}, 32'd0);
        chk("rst_abort_dout", mem_dout, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end

endmodule
